// File: rtl/ocs_pkg.sv
// Shared types, FSM encodings and helper functions for the OCS permutation tester.
package ocs_pkg;

  // Permutation pattern selected at the start of a run.
  typedef enum logic [1:0] {
    MODE_RANDOM   = 2'd0,
    MODE_IDENTITY = 2'd1,
    MODE_ROTATE   = 2'd2,
    MODE_REVERSE  = 2'd3
  } mode_e;

  // Top-level FSM encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_GEN      = 3'd1;
  localparam state_t ST_ISSUE    = 3'd2;
  localparam state_t ST_WAIT_GNT = 3'd3;
  localparam state_t ST_DRIVE    = 3'd4;
  localparam state_t ST_CHECK    = 3'd5;
  localparam state_t ST_NEXT     = 3'd6;

  // Right-shifting Galois LFSR mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Widest lane vector the identity helper can build.
  localparam int unsigned MAX_VEC_W = 512;

  // Identity vector: lane k carries the value k, lanes are dst_w bits wide.
  function automatic logic [MAX_VEC_W-1:0] identity_vec(input int unsigned dst_w);
    logic [MAX_VEC_W-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < (32'd1 << dst_w); k++) begin
      for (int unsigned b = 0; b < dst_w; b++) begin
        if ((k * dst_w + b) < MAX_VEC_W) v[k*dst_w+b] = k[b];
      end
    end
    return v;
  endfunction

  // One Galois LFSR step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Saturating 16-bit increment used by the run counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ocs_perm_gen.sv
// Permutation generator: fills one destination slot per enabled cycle and
// strobes o_done on the cycle the last slot is written.
module ocs_perm_gen
  import ocs_pkg::*;
#(
  parameter int          P_DSTWIDTH = 3,
  parameter int          P_PORTNUM  = 2**P_DSTWIDTH,
  parameter logic [15:0] P_SEED     = 16'hACE1,
  parameter int          P_MAXTRY   = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_en,
  input  mode_e                           i_mode,
  input  logic [P_DSTWIDTH-1:0]           i_rot,
  output logic [P_PORTNUM*P_DSTWIDTH-1:0] o_perm,
  output logic                            o_done
);

  localparam int TRY_W = $clog2(P_MAXTRY + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(P_MAXTRY);
  localparam logic [P_DSTWIDTH-1:0] SLOT_LAST = P_DSTWIDTH'(P_PORTNUM - 1);

  logic [15:0]                     lfsr_q, lfsr_d;
  logic [P_DSTWIDTH-1:0]           slot_q, slot_d;
  logic [P_PORTNUM-1:0]            used_q, used_d;
  logic [TRY_W-1:0]                try_q, try_d;
  logic [P_PORTNUM*P_DSTWIDTH-1:0] perm_q, perm_d;

  logic [P_DSTWIDTH-1:0] cand;
  logic [P_DSTWIDTH-1:0] lowest_free;
  logic [P_DSTWIDTH-1:0] pick;
  logic                  take;
  logic                  done;

  // Choose this slot's destination and advance LFSR, mask and slot pointer.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    lfsr_d      = lfsr_q;
    slot_d      = slot_q;
    used_d      = used_q;
    try_d       = try_q;
    perm_d      = perm_q;
    done        = 1'b0;
    pick        = '0;
    take        = 1'b0;
    cand        = lfsr_q[P_DSTWIDTH-1:0];
    lowest_free = '0;
    for (int i = P_PORTNUM - 1; i >= 0; i--) begin
      if (!used_q[i]) lowest_free = P_DSTWIDTH'(i);
    end

    case (i_mode)
      MODE_RANDOM: begin
        if (!used_q[cand]) begin
          pick = cand;
          take = 1'b1;
        end else if (try_q == TRY_LAST) begin
          // Too many collisions on this slot: fall back to the lowest free index.
          pick = lowest_free;
          take = 1'b1;
        end
      end
      MODE_IDENTITY: begin
        pick = slot_q;
        take = 1'b1;
      end
      MODE_ROTATE: begin
        pick = slot_q + i_rot;
        take = 1'b1;
      end
      default: begin
        pick = ~slot_q;
        take = 1'b1;
      end
    endcase

    if (i_en) begin
      lfsr_d = lfsr_step(lfsr_q);
      if (take) begin
        perm_d[slot_q*P_DSTWIDTH +: P_DSTWIDTH] = pick;
        used_d[pick] = 1'b1;
        try_d        = '0;
        if (slot_q == SLOT_LAST) begin
          // Leave pointer and mask clean for the next test.
          slot_d = '0;
          used_d = '0;
          done   = 1'b1;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end else begin
        try_d = try_q + 1'b1;
      end
    end
  end

  // Generator state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      lfsr_q <= P_SEED;
      slot_q <= '0;
      used_q <= '0;
      try_q  <= '0;
      // NOTE: the permutation store is a handful of flops, not a RAM, so it is reset along with everything else.
      perm_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      slot_q <= slot_d;
      used_q <= used_d;
      try_q  <= try_d;
      perm_q <= perm_d;
    end
  end

  assign o_perm = perm_q;
  assign o_done = done;

endmodule

// File: rtl/ocs_perm_tester.sv
// Self-test engine for the controller -> grant -> OCS data-plane path:
// generates a permutation, requests it, forwards the grant, drives the
// permutation as data and checks that the fabric returns the identity vector.
module ocs_perm_tester
  import ocs_pkg::*;
#(
  parameter int          P_DSTWIDTH   = 3,
  parameter int          P_PORTNUM    = 2**P_DSTWIDTH,
  parameter int          P_GRANTWIDTH = 20,
  parameter int          P_TIMEOUT    = 1024,
  parameter int          P_RETLAT     = 0,
  parameter logic [15:0] P_SEED       = 16'hACE1,
  parameter int          P_MAXTRY     = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_start,
  input  logic [1:0]                      i_mode,
  input  logic [15:0]                     i_num_tests,
  input  logic                            i_stop,
  output logic [P_PORTNUM*P_DSTWIDTH-1:0] o_req,
  output logic                            o_req_valid,
  input  logic [P_GRANTWIDTH-1:0]         i_grant,
  input  logic                            i_grant_valid,
  output logic [P_GRANTWIDTH-1:0]         o_grant,
  output logic [P_PORTNUM*P_DSTWIDTH-1:0] o_data,
  output logic                            o_data_valid,
  input  logic [P_PORTNUM*P_DSTWIDTH-1:0] i_data,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [15:0]                     o_test_cnt,
  output logic [15:0]                     o_err_cnt,
  output logic [15:0]                     o_tmo_cnt
);

  localparam int VEC_W = P_PORTNUM * P_DSTWIDTH;
  localparam int TMO_W = $clog2(P_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_TIMEOUT - 1);
  localparam logic [2:0] RET_LAST = 3'(P_RETLAT);
  localparam logic [MAX_VEC_W-1:0] ID_FULL = identity_vec(P_DSTWIDTH);
  localparam logic [VEC_W-1:0] ID_VEC = ID_FULL[VEC_W-1:0];

  state_t                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [15:0]             num_q, num_d;
  logic                    stop_q, stop_d;
  logic [P_DSTWIDTH-1:0]   rot_q, rot_d;
  logic [TMO_W-1:0]        timer_q, timer_d;
  logic [2:0]              ret_q, ret_d;
  logic [VEC_W-1:0]        req_q, req_d;
  logic                    req_valid_q, req_valid_d;
  logic [P_GRANTWIDTH-1:0] grant_q, grant_d;
  logic [VEC_W-1:0]        data_q, data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    done_q, done_d;
  logic [15:0]             test_cnt_q, test_cnt_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic [15:0]             tmo_cnt_q, tmo_cnt_d;

  logic             gen_en;
  logic             gen_done;
  logic [VEC_W-1:0] gen_perm;

  ocs_perm_gen #(
    .P_DSTWIDTH (P_DSTWIDTH),
    .P_PORTNUM  (P_PORTNUM),
    .P_SEED     (P_SEED),
    .P_MAXTRY   (P_MAXTRY)
  ) u_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (gen_en),
    .i_mode  (mode_q),
    .i_rot   (rot_q),
    .o_perm  (gen_perm),
    .o_done  (gen_done)
  );

  // Test sequencing FSM with its counters and output strobes.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    num_d        = num_q;
    stop_d       = stop_q;
    rot_d        = rot_q;
    timer_d      = timer_q;
    ret_d        = ret_q;
    req_d        = req_q;
    req_valid_d  = 1'b0;
    grant_d      = grant_q;
    data_d       = '0;
    data_valid_d = 1'b0;
    done_d       = 1'b0;
    test_cnt_d   = test_cnt_q;
    err_cnt_d    = err_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    gen_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          mode_d     = mode_e'(i_mode);
          num_d      = i_num_tests;
          stop_d     = 1'b0;
          test_cnt_d = '0;
          err_cnt_d  = '0;
          tmo_cnt_d  = '0;
          state_d    = ST_GEN;
        end
      end
      ST_GEN: begin
        gen_en = 1'b1;
        if (gen_done) state_d = ST_GEN + 3'd1;
      end
      ST_ISSUE: begin
        req_d       = gen_perm;
        req_valid_d = 1'b1;
        timer_d     = '0;
        state_d     = ST_WAIT_GNT;
      end
      ST_WAIT_GNT: begin
        // A grant arriving on the expiry cycle still counts as a grant.
        if (i_grant_valid) begin
          grant_d = i_grant;
          state_d = ST_DRIVE;
        end else if (timer_q == TMO_LAST) begin
          tmo_cnt_d = sat_inc(tmo_cnt_q);
          state_d   = ST_NEXT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        data_d       = req_q;
        data_valid_d = 1'b1;
        ret_d        = '0;
        state_d      = ST_CHECK;
      end
      ST_CHECK: begin
        // o_data_valid is high in the first CHECK cycle; the fabric answers P_RETLAT cycles later.
        if (ret_q == RET_LAST) begin
          if (i_data != ID_VEC) err_cnt_d = sat_inc(err_cnt_q);
          test_cnt_d = sat_inc(test_cnt_q);
          state_d    = ST_NEXT;
        end else begin
          ret_d = ret_q + 1'b1;
        end
      end
      ST_NEXT: begin
        rot_d = rot_q + 1'b1;
        if (((num_q != 16'd0) && (test_cnt_q == num_q)) || stop_q || i_stop) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GEN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && i_stop) stop_d = 1'b1;
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_RANDOM;
      num_q        <= '0;
      stop_q       <= 1'b0;
      rot_q        <= P_DSTWIDTH'(1);
      timer_q      <= '0;
      ret_q        <= '0;
      req_q        <= '0;
      req_valid_q  <= 1'b0;
      grant_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      test_cnt_q   <= '0;
      err_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      num_q        <= num_d;
      stop_q       <= stop_d;
      rot_q        <= rot_d;
      timer_q      <= timer_d;
      ret_q        <= ret_d;
      req_q        <= req_d;
      req_valid_q  <= req_valid_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      test_cnt_q   <= test_cnt_d;
      err_cnt_q    <= err_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign o_req        = req_q;
  assign o_req_valid  = req_valid_q;
  assign o_grant      = grant_q;
  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = done_q;
  assign o_test_cnt   = test_cnt_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_tmo_cnt    = tmo_cnt_q;

endmodule

// File: tb/tb_ocs_perm_tester.sv
// Scoreboard bench for ocs_perm_tester: stimulus pushes expected requests and
// end-of-run counters, a monitor pops and compares as the DUT presents them.
module tb_ocs_perm_tester;

  localparam int DW = 3;
  localparam int N  = 8;
  localparam int GW = 20;
  localparam int VW = N * DW;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [1:0]    i_mode = 2'd0;
  logic [15:0]   i_num_tests = 16'd0;
  logic          i_stop = 1'b0;
  logic [VW-1:0] o_req;
  logic          o_req_valid;
  logic [GW-1:0] i_grant = '0;
  logic          i_grant_valid = 1'b0;
  logic [GW-1:0] o_grant;
  logic [VW-1:0] o_data;
  logic          o_data_valid;
  logic [VW-1:0] i_data;
  logic          o_busy;
  logic          o_done;
  logic [15:0]   o_test_cnt;
  logic [15:0]   o_err_cnt;
  logic [15:0]   o_tmo_cnt;

  always #5 i_clk = ~i_clk;

  ocs_perm_tester #(
    .P_DSTWIDTH   (DW),
    .P_PORTNUM    (N),
    .P_GRANTWIDTH (GW),
    .P_TIMEOUT    (16),
    .P_RETLAT     (0),
    .P_SEED       (16'hACE1),
    .P_MAXTRY     (8)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_mode        (i_mode),
    .i_num_tests   (i_num_tests),
    .i_stop        (i_stop),
    .o_req         (o_req),
    .o_req_valid   (o_req_valid),
    .i_grant       (i_grant),
    .i_grant_valid (i_grant_valid),
    .o_grant       (o_grant),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .i_data        (i_data),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_test_cnt    (o_test_cnt),
    .o_err_cnt     (o_err_cnt),
    .o_tmo_cnt     (o_tmo_cnt)
  );

  typedef struct {
    logic          any_perm;
    logic [VW-1:0] req;
  } req_exp_t;

  typedef struct {
    logic [15:0] tests;
    logic [15:0] errs;
    logic [15:0] tmos;
  } done_exp_t;

  req_exp_t  req_q[$];
  done_exp_t done_q[$];
  req_exp_t  mon_req;
  done_exp_t mon_done;

  int n_checks = 0;
  int n_pass   = 0;

  int            withhold_at = -1;
  int            flip_at     = -1;
  int            req_total   = 0;
  int            data_total  = 0;
  logic [VW-1:0] ctrl_req    = '0;
  logic [GW-1:0] last_grant  = '0;
  logic [VW-1:0] fab;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic is_perm(input logic [VW-1:0] v);
    logic [N-1:0] seen;
    seen = '0;
    for (int i = 0; i < N; i++) seen[v[i*DW +: DW]] = 1'b1;
    return &seen;
  endfunction

  // Controller model: grants every request one cycle later unless told to withhold it.
  initial begin
    forever begin
      @(negedge i_clk);
      i_grant_valid = 1'b0;
      if (i_rst_n && o_req_valid) begin
        ctrl_req = o_req;
        if (req_total != withhold_at) begin
          i_grant       = o_req[GW-1:0] ^ 20'hA5C3F;
          i_grant_valid = 1'b1;
          last_grant    = i_grant;
        end
        req_total++;
      end
    end
  end

  // Data returned by the fabric.
  always @(posedge i_clk) if (o_data_valid) data_total <= data_total + 1;

  // Fabric model: port i's data lands on output lane ctrl_req[i]; optional bit-0 corruption.
  always_comb begin
    fab = '0;
    for (int i = 0; i < N; i++) fab[ctrl_req[i*DW +: DW]*DW +: DW] = o_data[i*DW +: DW];
    if (o_data_valid && (data_total == flip_at)) fab[0] = ~fab[0];
    i_data = o_data_valid ? fab : '0;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a request, data or done.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_req_valid) begin
        if (req_q.size() == 0) begin
          check("req_unexpected", 32'(req_q.size()), 32'd1);
        end else begin
          mon_req = req_q.pop_front();
          if (mon_req.any_perm) check("req_is_perm", 32'(is_perm(o_req)), 32'd1);
          else check("req_value", 32'(o_req), 32'(mon_req.req));
        end
      end
      if (o_data_valid) check("grant_fwd", 32'(o_grant), 32'(last_grant));
      if (o_done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 32'(done_q.size()), 32'd1);
        end else begin
          mon_done = done_q.pop_front();
          check("done_test_cnt", 32'(o_test_cnt), 32'(mon_done.tests));
          check("done_err_cnt", 32'(o_err_cnt), 32'(mon_done.errs));
          check("done_tmo_cnt", 32'(o_tmo_cnt), 32'(mon_done.tmos));
          check("done_busy", 32'(o_busy), 32'd0);
        end
      end
    end
  end

  task automatic push_req(input logic [VW-1:0] v, input int n);
    for (int i = 0; i < n; i++) req_q.push_back('{any_perm: 1'b0, req: v});
  endtask

  task automatic push_done(input logic [15:0] t, input logic [15:0] e, input logic [15:0] m);
    done_q.push_back('{tests: t, errs: e, tmos: m});
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic run(input logic [1:0] mode, input logic [15:0] num);
    @(negedge i_clk);
    i_mode      = mode;
    i_num_tests = num;
    i_start     = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int cyc;
    cyc = 0;
    while (!o_req_valid && cyc < 200) begin
      @(negedge i_clk);
      cyc++;
    end
    check({name, "_req_seen"}, 32'(o_req_valid), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int cyc;
    cyc = 0;
    while ((req_q.size() != 0 || done_q.size() != 0) && cyc < budget) begin
      @(negedge i_clk);
      cyc++;
    end
    check({name, "_finished"}, 32'(req_q.size() + done_q.size()), 32'd0);
    if (req_q.size() != 0 || done_q.size() != 0) begin
      req_q.delete();
      done_q.delete();
      apply_reset();
    end
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Reset state.
    repeat (3) @(negedge i_clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_req", 32'(o_req), 32'd0);
    check("rst_req_valid", 32'(o_req_valid), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_data_valid", 32'(o_data_valid), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_test_cnt", 32'(o_test_cnt), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Rotate, two tests: rot=1 then rot=2; a mid-run i_start must be ignored.
    push_req(24'h1F58D1, 1);
    push_req(24'h23EB1A, 1);
    push_done(16'd2, 16'd0, 16'd0);
    run(2'd2, 16'd2);
    wait_req("rot");
    i_start     = 1'b1;
    i_mode      = 2'd1;
    i_num_tests = 16'd7;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_idle("rot", 300);

    // Identity, one test.
    push_req(24'hFAC688, 1);
    push_done(16'd1, 16'd0, 16'd0);
    run(2'd1, 16'd1);
    wait_idle("ident", 200);

    // Reverse, one test.
    push_req(24'h053977, 1);
    push_done(16'd1, 16'd0, 16'd0);
    run(2'd3, 16'd1);
    wait_idle("rev", 200);

    // Bit 0 of the returned data corrupted on test 3 of 5.
    flip_at = data_total + 2;
    push_req(24'hFAC688, 5);
    push_done(16'd5, 16'd1, 16'd0);
    run(2'd1, 16'd5);
    wait_idle("flip", 500);
    flip_at = -1;

    // First grant withheld: timeout after 16 WAIT_GNT cycles, then two good tests.
    withhold_at = req_total;
    push_req(24'hFAC688, 3);
    push_done(16'd2, 16'd0, 16'd1);
    run(2'd1, 16'd2);
    wait_req("tmo");
    n = 0;
    while (o_tmo_cnt == 16'd0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("tmo_latency", 32'(n), 32'd16);
    check("tmo_test_cnt_hold", 32'(o_test_cnt), 32'd0);
    wait_idle("tmo", 300);
    withhold_at = -1;

    // Random mode, 1000 tests.
    for (int i = 0; i < 1000; i++) req_q.push_back('{any_perm: 1'b1, req: '0});
    push_done(16'd1000, 16'd0, 16'd0);
    run(2'd0, 16'd1000);
    wait_idle("rand", 60000);

    // Endless run finished by i_stop after its first test.
    push_req(24'hFAC688, 1);
    push_done(16'd1, 16'd0, 16'd0);
    run(2'd1, 16'd0);
    wait_req("stop");
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
    wait_idle("stop", 200);

    // Reset asserted during WAIT_GNT: outputs clear at once, no done.
    withhold_at = req_total;
    push_req(24'hFAC688, 1);
    run(2'd1, 16'd1);
    wait_req("mid_rst");
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_req", 32'(o_req), 32'd0);
    check("mid_rst_tmo_cnt", 32'(o_tmo_cnt), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    withhold_at = -1;
    @(negedge i_clk);

    // Fresh start after reset: rotate offset back to 1.
    push_req(24'h1F58D1, 1);
    push_done(16'd1, 16'd0, 16'd0);
    run(2'd2, 16'd1);
    wait_idle("post_rst", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
